// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the execute-stage ALU.
//   alu_op_e : operation select codes carried on ALUControl
//   FLAG_*   : bit positions of N, Z, C and V inside ALUFlags
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub
// Combinational WIDTH-bit adder/subtractor shared by ADD and SUB.
//   A, B     : operands
//   sub      : 0 = A + B, 1 = A + ~B + 1
//   sum      : low WIDTH bits of the result
//   carry    : carry out of the top bit (for SUB, 1 means no borrow)
//   overflow : two's-complement overflow
module alu_addsub #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    // Subtraction reuses the adder: invert B and inject the +1 as carry-in.
    always_comb begin
        b_eff    = sub ? ~B : B;
        full     = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum      = full[WIDTH-1:0];
        carry    = full[WIDTH];
        // Overflow when both adder inputs share a sign the sum does not.
        // For SUB this is "A and B differ in sign, result differs from A".
        overflow = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    end

endmodule

// File: rtl/alu.sv
// alu
// Registered integer ALU with NZCV flags, one cycle of latency.
//   clk, rst_n  : clock and asynchronous active-low reset
//   in_valid    : capture A, B and ALUControl on this rising edge
//   A, B        : WIDTH-bit operands
//   ALUControl  : 00 ADD, 01 SUB, 10 AND, 11 OR
//   Result      : registered result
//   ALUFlags    : registered flags {N, Z, C, V}
//   out_valid   : one-cycle pulse when Result/ALUFlags were just loaded
module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags,
    output logic             out_valid
);

    import alu_pkg::*;

    alu_op_e          op;
    logic             sub_sel;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_overflow;
    logic [WIDTH-1:0] and_result;
    logic [WIDTH-1:0] or_result;
    logic [WIDTH-1:0] next_result;
    logic [3:0]       next_flags;

    assign op         = alu_op_e'(ALUControl);
    assign sub_sel    = (op == ALU_SUB);
    assign and_result = A & B;
    assign or_result  = A | B;

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .A        (A),
        .B        (B),
        .sub      (sub_sel),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_overflow)
    );

    // Result mux and flag generation. C and V only come from the adder
    // path; the logic operations leave them clear.
    always_comb begin
        next_result = '0;
        next_flags  = '0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                next_result         = as_sum;
                next_flags[FLAG_C]  = as_carry;
                next_flags[FLAG_V]  = as_overflow;
            end
            ALU_AND: next_result = and_result;
            ALU_OR:  next_result = or_result;
            default: next_result = '0;
        endcase
        next_flags[FLAG_N] = next_result[WIDTH-1];
        next_flags[FLAG_Z] = (next_result == '0);
    end

    // Result and flags load together so they always describe one operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result    <= '0;
            ALUFlags  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Result   <= next_result;
                ALUFlags <= next_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu
// Scoreboard bench for alu (WIDTH=4): directed cases plus random traffic,
// expectations from an integer-arithmetic model, checked by a monitor.
module tb_alu;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] result;
        logic [3:0]   flags;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [1:0]   ALUControl;
    logic [W-1:0] Result;
    logic [3:0]   ALUFlags;
    logic         out_valid;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .Result     (Result),
        .ALUFlags   (ALUFlags),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int a, input int b, input int op);
        exp_t e;
        int r, sa, sb, sr, c, v;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        c  = 0;
        v  = 0;
        r  = 0;
        case (op)
            0: begin
                r  = a + b;
                c  = (r >= 16) ? 1 : 0;
                r  = r % 16;
                sr = sa + sb;
                v  = (sr > 7 || sr < -8) ? 1 : 0;
            end
            1: begin
                r  = (a - b + 16) % 16;
                c  = (a >= b) ? 1 : 0;
                sr = sa - sb;
                v  = (sr > 7 || sr < -8) ? 1 : 0;
            end
            2: r = a & b;
            default: r = a | b;
        endcase
        e.result = r[W-1:0];
        e.flags  = {(r >= 8) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0, c[0], v[0]};
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Drive one operation, then log its expectation once the capture edge passes.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        @(negedge clk);
        A          = a;
        B          = b;
        ALUControl = op;
        in_valid   = 1'b1;
        @(posedge clk);
        sb_q.push_back(model(int'(a), int'(b), int'(op)));
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        A        = $urandom_range(0, 15);
        B        = $urandom_range(0, 15);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every out_valid pulse must match the oldest expectation, and
    // every expectation must be answered on the cycle after its capture.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_out_valid", 16'd1, 16'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checkOutput("result_flags", {8'h00, Result, ALUFlags}, {8'h00, e.result, e.flags});
                end
            end else if (sb_q.size() != 0) begin
                void'(sb_q.pop_front());
                checkOutput("missing_out_valid", 16'd0, 16'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [W-1:0] da [11];
        logic [W-1:0] db [11];
        logic [1:0]   dop[11];
        da  = '{4'b0101, 4'b0010, 4'b0111, 4'b0010, 4'b0111, 4'b1111, 4'b0101, 4'b1000, 4'b0000, 4'b1000, 4'b0111};
        db  = '{4'b0010, 4'b0101, 4'b1000, 4'b0101, 4'b0001, 4'b0001, 4'b0101, 4'b0001, 4'b0001, 4'b1000, 4'b1111};
        dop = '{2'b11,   2'b10,   2'b00,   2'b01,   2'b00,   2'b00,   2'b01,   2'b01,   2'b01,   2'b00,   2'b01};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        A          = '0;
        B          = '0;
        ALUControl = '0;
        #12;
        checkOutput("reset_state", {7'd0, out_valid, Result, ALUFlags}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        $display("[TB] directed cases");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(da[i], db[i], dop[i]);
            idle(1);
        end

        $display("[TB] back-to-back directed cases");
        for (int i = 0; i < 11; i++) applyStimulus(da[i], db[i], dop[i]);
        idle(2);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
        end
        idle(2);

        $display("[TB] reset mid-stream");
        applyStimulus(4'b0111, 4'b0001, 2'b00);
        applyStimulus(4'b1111, 4'b1111, 2'b11);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        checkOutput("async_reset_clear", {7'd0, out_valid, Result, ALUFlags}, 16'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("hold_after_reset", {7'd0, out_valid, Result, ALUFlags}, 16'd0);
        end

        $display("[TB] first operation after reset");
        applyStimulus(4'b0101, 4'b0010, 2'b11);
        idle(2);
        checkOutput("scoreboard_drained", 16'(sb_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Parameterised integer ALU for the datapath execute stage. It takes two operands and a 2-bit operation select and produces a result plus NZCV condition flags. Both the result and the flags are registered, so they appear one clock after the operands are presented. The flags feed the condition-check logic downstream.

## Interface
- `WIDTH`, default 4: operand and result width in bits. Must be ≥ 2.
- `clk`  input  1: rising-edge clock.
- `rst_n`  input  1: asynchronous, active-low reset.
- `in_valid`  input  1: when high, the operands and op select are captured this cycle.
- `A`  input  WIDTH: operand A.
- `B`  input  WIDTH: operand B.
- `ALUControl`  input  2: operation select. 00 ADD, 01 SUB, 10 AND, 11 OR.
- `Result`  output  WIDTH: registered result.
- `ALUFlags`  output  4: registered flags. [3]=N, [2]=Z, [1]=C, [0]=V.
- `out_valid`  output  1: high for one cycle when Result and ALUFlags hold a newly computed value.

## Operation
- ADD (00): `sum = A + B`, computed WIDTH+1 bits wide.
  - Result = sum[WIDTH-1:0].
  - C = sum[WIDTH].
- SUB (01): `A + ~B + 1`, computed WIDTH+1 bits wide.
  - Result = low WIDTH bits.
  - C = carry out, so C=1 means no borrow (A ≥ B unsigned).
- AND (10): Result = A & B. C = 0, V = 0.
- OR (11): Result = A | B. C = 0, V = 0.
- N = Result[WIDTH-1] for every operation.
- Z = 1 when Result equals 0, for every operation.
- V for ADD: set when A and B have the same sign and Result's sign differs from it.
- V for SUB: set when A and B have different signs and Result's sign differs from A's sign.
- Results wrap modulo 2^WIDTH. No saturation.
- All four results are computed combinationally in parallel; ALUControl drives a mux.
- Within a WIDTH, no input combination is illegal. Every ALUControl code is defined.

## Timing
- Latency is 1 cycle. On the rising edge where in_valid=1:
  - Result and ALUFlags load the value computed from that cycle's A, B and ALUControl.
  - out_valid goes to 1 for the following cycle.
- When in_valid=0 at an edge:
  - Result and ALUFlags hold their previous values.
  - out_valid goes to 0.
- Back-to-back operation: in_valid may stay high every cycle, giving one result per cycle. There is no stall and no backpressure.
- Reset: rst_n low immediately clears Result to 0, ALUFlags to 0000 and out_valid to 0, regardless of clk.
- Reset asserted mid-operation discards the in-flight capture. The first valid input after rst_n deasserts is processed normally.
- The flags always belong to the same operation as Result; they never mix two operations.

## Structure
- Shared package `alu_pkg` holds:
  - An enum for the ALUControl codes: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
  - Localparams for the flag bit indices: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, `alu_addsub`:
  - Combinational, WIDTH-parameterised adder/subtractor.
  - Inputs: A, B and a sub select. Outputs: sum, carry and overflow.
- The top level contains the logic unit, the result mux, the flag generation and the output registers.

## Test plan
All cases use WIDTH=4 with in_valid pulsed for one cycle. Each check is made one cycle after capture, with out_valid=1.
- OR: A=0101, B=0010, ALUControl=11 -> Result=0111, ALUFlags=0000.
- AND: A=0010, B=0101, ALUControl=10 -> Result=0000, ALUFlags=0100 (Z).
- ADD: A=0111, B=1000, ALUControl=00 -> Result=1111, ALUFlags=1000 (N).
- SUB: A=0010, B=0101, ALUControl=01 -> Result=1101, ALUFlags=1000 (N, borrow so C=0).
- Overflow and carry:
  - ADD 0111+0001 -> Result=1000, ALUFlags=1001 (N, V).
  - ADD 1111+0001 -> Result=0000, ALUFlags=0110 (Z, C).
  - SUB 0101-0101 -> Result=0000, ALUFlags=0110 (Z, C).
- Reset and hold:
  - Assert rst_n low mid-stream, between clock edges -> Result=0000, ALUFlags=0000 and out_valid=0 immediately.
  - After rst_n releases, hold in_valid=0 for 3 cycles -> outputs stay 0.
